// File: rtl/ukf_sigma_sched.sv
`default_nettype none
// ============================================================================
// Module  : ukf_sigma_sched
// Purpose : Issues the sigma points of one UKF pass with a bound on points in
//           flight and tracks their returns. The optional watchdog is built
//           when UKF_SCHED_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module ukf_sigma_sched #(
  parameter int N_STATE     = 6,
  parameter int N_SIGMA     = 2*N_STATE+1,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       iss_valid,
  input  logic       iss_ready,
  output logic [3:0] iss_idx,
  output logic       iss_mode,
  input  logic       ret_valid,
  input  logic [3:0] ret_idx,
  output logic       err,
  output logic       timeout
);

  localparam int W_ISS = $clog2(N_SIGMA + 1);
  localparam int W_OUT = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [W_ISS-1:0]   r_issued;
  logic [W_OUT-1:0]   r_out;
  logic [N_SIGMA-1:0] r_bitmap;
  logic               r_mode;
  logic               r_err;

  logic               w_active;
  logic               w_can_issue;
  logic               w_fire;
  logic               w_in_range;
  logic               w_seen;
  logic [N_SIGMA-1:0] w_mask;
  logic               w_legal;
  logic               w_bad;
  logic [W_ISS-1:0]   w_issued_next;
  logic [W_OUT-1:0]   w_out_next;
  logic [N_SIGMA-1:0] w_bitmap_next;
  logic               w_wd_hit;

  assign w_active    = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_can_issue = (r_state == ISSUE) && (r_issued < W_ISS'(N_SIGMA))
                       && (r_out < W_OUT'(MAX_OUT));
  assign w_fire      = w_can_issue & iss_ready;

  assign iss_valid = w_can_issue;
  assign iss_idx   = 4'(r_issued);
  assign iss_mode  = r_mode;
  assign err       = r_err;

  // A return is legal only for an issued index that has not come back yet.
  always_comb begin
    w_seen = 1'b0;
    w_mask = '0;
    for (int i = 0; i < N_SIGMA; i++) begin
      if (ret_idx == 4'(i)) begin
        w_seen    = r_bitmap[i];
        w_mask[i] = 1'b1;
      end
    end
  end

  assign w_in_range    = (32'(ret_idx) < 32'(r_issued));
  assign w_legal       = w_active & ret_valid & w_in_range & ~w_seen;
  assign w_bad         = ret_valid & ((w_active & ~w_legal) | (r_state == DONE));
  assign w_bitmap_next = w_legal ? (r_bitmap | w_mask) : r_bitmap;
  assign w_issued_next = r_issued + W_ISS'(w_fire);

  always_comb begin
    w_out_next = r_out;
    case ({w_fire, w_legal})
      2'b10:   w_out_next = r_out + W_OUT'(1);
      2'b01:   w_out_next = r_out - W_OUT'(1);
      default: w_out_next = r_out;
    endcase
  end

`ifdef UKF_SCHED_TIMEOUT_EN
  localparam int W_WD = $clog2(TIMEOUT_CYC + 1);

  logic [W_WD-1:0] r_wd;
  logic [W_WD-1:0] w_wd_next;
  logic            r_timeout;

  assign w_wd_next = (w_fire | w_legal) ? '0 : r_wd + W_WD'(1);
  assign w_wd_hit  = w_active && (w_wd_next == W_WD'(TIMEOUT_CYC));
  assign timeout   = r_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= w_active ? w_wd_next : '0;
      if (w_wd_hit) r_timeout <= 1'b1;
    end
  end
`else
  assign w_wd_hit = 1'b0;
  // Constant 0 for any legal (positive) TIMEOUT_CYC.
  assign timeout  = (TIMEOUT_CYC < 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    case (r_state)
      IDLE:  if (start) w_state_next = ISSUE;
      ISSUE: begin
        if (w_wd_hit)
          w_state_next = DONE;
        else if (w_issued_next == W_ISS'(N_SIGMA))
          w_state_next = (&w_bitmap_next) ? DONE : DRAIN;
      end
      DRAIN: if (w_wd_hit || (&w_bitmap_next)) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issued <= '0;
      r_out    <= '0;
      r_bitmap <= '0;
      r_mode   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_issued <= '0;
      r_out    <= '0;
      r_bitmap <= '0;
      r_mode   <= mode;
      r_err    <= 1'b0;
    end else begin
      r_issued <= w_issued_next;
      r_out    <= w_out_next;
      r_bitmap <= w_bitmap_next;
      if (w_bad) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/ukf_sigma_sched.md
UKF_SIGMA_SCHED -- requirements
Module: ukf_sigma_sched

Interface
REQ-001 SHALL have parameter N_STATE, default 6, state dimension.
REQ-002 SHALL have parameter N_SIGMA, default 2*N_STATE+1, sigma points per pass.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum issued-not-returned sigma points (1..N_SIGMA).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles (used only with UKF_SCHED_TIMEOUT_EN).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have ports start (input, 1, begin one pass) and mode (input, 1, 0=process-model propagate, 1=measurement transform; sampled with start).
REQ-008 SHALL have ports busy (output, 1, pass in progress) and done (output, 1, one-cycle end-of-pass pulse).
REQ-009 SHALL have ports iss_valid (output, 1), iss_ready (input, 1), iss_idx (output, 4, sigma index), iss_mode (output, 1, latched mode).
REQ-010 SHALL have ports ret_valid (input, 1, result returned) and ret_idx (input, 4, index of returned result).
REQ-011 SHALL have ports err (output, 1, sticky illegal-return flag) and timeout (output, 1, sticky watchdog flag).

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN, DONE; busy=1 in every state except IDLE.
REQ-013 IDLE: start=1 SHALL latch mode, clear issue count, outstanding count, return bitmap (N_SIGMA bits), err and timeout, and go to ISSUE next cycle; start outside IDLE SHALL be ignored.
REQ-014 ISSUE: iss_valid SHALL be 1 when issued count < N_SIGMA and outstanding < MAX_OUT; iss_idx SHALL equal issued count (0 first, ascending).
REQ-015 Once asserted, iss_valid, iss_idx and iss_mode SHALL hold stable until iss_valid&iss_ready.
REQ-016 An issue transfer (iss_valid&iss_ready) SHALL increment issued count and outstanding count.
REQ-017 ret_valid SHALL always be accepted (no back-pressure) in ISSUE and DRAIN; a legal return SHALL set bitmap[ret_idx] and decrement outstanding.
REQ-018 A return is legal only if ret_idx < issued count and bitmap[ret_idx]=0; otherwise err SHALL set and bitmap/outstanding SHALL be unchanged.
REQ-019 ret_valid in IDLE or DONE SHALL set err only if it occurs in DONE; in IDLE it SHALL be ignored.
REQ-020 Same-cycle issue transfer and legal return SHALL leave outstanding unchanged and increment issued count.
REQ-021 ISSUE SHALL move to DRAIN the cycle after the N_SIGMA-th issue transfer.
REQ-022 DRAIN SHALL move to DONE the cycle after the bitmap becomes all-ones; if the final return coincides with the final issue, ISSUE SHALL go directly to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE; done latency = 1 cycle after last legal return accepted.
REQ-024 Counters SHALL be wide enough for N_SIGMA and MAX_OUT without wrap; outstanding SHALL never exceed MAX_OUT nor go below 0.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, iss_valid=0, iss_idx=0, iss_mode=0, err=0, timeout=0, all counters and bitmap 0.
REQ-026 Reset mid-pass SHALL abandon the pass with no done pulse; later returns from the abandoned pass arriving in IDLE SHALL be ignored.

Configuration
REQ-027 Macro UKF_SCHED_TIMEOUT_EN defined: a watchdog SHALL count cycles in ISSUE/DRAIN without any transfer or legal return, reset on either; on reaching TIMEOUT_CYC it SHALL set timeout and go to DONE (done pulses, pass aborted).
REQ-028 Macro undefined: no watchdog logic SHALL exist; timeout SHALL be constant 0.

Verification
REQ-029 iss_ready=1, each return 3 cycles after issue, MAX_OUT=4 -> indices 0..12 issued in order, 13 returns, single done pulse, err=0.
REQ-030 Returns withheld -> exactly 4 issues (idx 0..3) then iss_valid=0; one return -> idx 4 issued next.
REQ-031 iss_ready=0 for 5 cycles with idx 2 pending -> iss_valid=1, iss_idx=2 held stable throughout.
REQ-032 Duplicate ret_idx=1, then ret_idx=14 -> err=1 after first, count unaffected, pass still completes with done.
REQ-033 rst_n=0 during DRAIN with 2 outstanding -> next cycle IDLE, busy=0, no done; stale returns ignored, err=0.
REQ-034 With UKF_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, no returns -> timeout=1 and done pulse 16 cycles after last activity; without macro -> busy stays 1, timeout=0.
